// File: rtl/fifo_ctrl_pkg.sv
// Shared constants and types for the synchronous 8-bit FIFO pointer/flag controller.
// Sizing defaults live here so the controller, array and bench agree.
package fifo_ctrl_pkg;

  localparam int FIFO_DEPTH     = 8;
  localparam int FIFO_ADDR_W    = 3;
  localparam int FIFO_DATA_W    = 8;
  localparam int FIFO_AFULL_TH  = 6;
  localparam int FIFO_AEMPTY_TH = 2;

  typedef logic [FIFO_ADDR_W-1:0] ptr_t;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Increment-with-wrap pointer register; wraps DEPTH-1 -> 0 by explicit compare,
// so non-power-of-two depths work.
module fifo_ptr_wrap
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = FIFO_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the FIFO storage array: qualifies requests,
// owns occupancy, full/empty thresholds, sticky errors and read-data-valid.
module fifo_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AFULL_TH  = FIFO_AFULL_TH,
  parameter int AEMPTY_TH = FIFO_AEMPTY_TH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic              clr,
  output logic              write_en,
  output logic              read_en,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] CNT_DEPTH  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_AFULL  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] CNT_AEMPTY = (ADDR_W+1)'(AEMPTY_TH);

  logic [ADDR_W:0] count_q, count_d;
  logic            rd_valid_q, rd_valid_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;

  // Flags decode only registered count, so they never see same-cycle requests.
  assign full         = (count_q == CNT_DEPTH);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AFULL);
  assign almost_empty = (count_q <= CNT_AEMPTY);

  // wr_req/rd_req are requests that may be refused; write_en/read_en mark the
  // accepted transfers, each taking effect on the rising edge of its cycle.
  assign write_en = wr_req & ~full  & ~clr;
  assign read_en  = rd_req & ~empty & ~clr;

  always_comb begin
    count_d     = count_q;
    rd_valid_d  = read_en;
    overflow_d  = overflow_q  | (wr_req & full  & ~clr);
    underflow_d = underflow_q | (rd_req & empty & ~clr);
    if (clr) begin
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (write_en && !read_en) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (read_en && !write_en) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  fifo_ptr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (write_en),
    .ptr   (wr_ptr)
  );

  fifo_ptr_wrap #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (read_en),
    .ptr   (rd_ptr)
  );

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl: reference model plus hand-computed checkpoints,
// with a write-address queue confirming reads follow write order.
module tb_fifo_ctrl;
  import fifo_ctrl_pkg::*;

  localparam int D = FIFO_DEPTH;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_req = 1'b0, rd_req = 1'b0, clr = 1'b0;
  logic       write_en, read_en, rd_valid;
  ptr_t       wr_ptr, rd_ptr;
  logic [3:0] count;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // reference model state
  int   m_count = 0;
  ptr_t m_wr = '0, m_rd = '0;
  logic m_rv = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;
  logic [FIFO_ADDR_W-1:0] exp_q[$];

  fifo_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .rd_req       (rd_req),
    .clr          (clr),
    .write_en     (write_en),
    .read_en      (read_en),
    .wr_ptr       (wr_ptr),
    .rd_ptr       (rd_ptr),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ptr_t inc_wrap(input ptr_t p);
    return (int'(p) == D - 1) ? '0 : p + ptr_t'(1);
  endfunction

  task automatic model_reset();
    m_count = 0; m_wr = '0; m_rd = '0;
    m_rv = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_state(input string tag);
    ptr_t diff;
    chk({tag, ":wr_ptr"}, 32'(wr_ptr), 32'(m_wr));
    chk({tag, ":rd_ptr"}, 32'(rd_ptr), 32'(m_rd));
    chk({tag, ":count"}, 32'(count), 32'(m_count));
    chk({tag, ":rd_valid"}, 32'(rd_valid), 32'(m_rv));
    chk({tag, ":full"}, 32'(full), 32'(m_count == D));
    chk({tag, ":empty"}, 32'(empty), 32'(m_count == 0));
    chk({tag, ":almost_full"}, 32'(almost_full), 32'(m_count >= FIFO_AFULL_TH));
    chk({tag, ":almost_empty"}, 32'(almost_empty), 32'(m_count <= FIFO_AEMPTY_TH));
    chk({tag, ":overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ":underflow"}, 32'(underflow), 32'(m_udf));
    diff = wr_ptr - rd_ptr;
    chk({tag, ":invariant"}, 32'(int'(diff) % D), 32'(int'(count) % D));
  endtask

  // One clock of stimulus: drive at negedge, check enables before the edge,
  // then check all registered state just after the edge.
  task automatic step(input logic wr, input logic rd, input logic c, input string tag);
    logic we, re, isfull, isempty;
    logic [FIFO_ADDR_W-1:0] exp_addr;
    @(negedge clk);
    wr_req = wr; rd_req = rd; clr = c;
    isfull  = (m_count == D);
    isempty = (m_count == 0);
    we = wr & ~isfull & ~c;
    re = rd & ~isempty & ~c;
    #1;
    chk({tag, ":write_en"}, 32'(write_en), 32'(we));
    chk({tag, ":read_en"}, 32'(read_en), 32'(re));
    if (re) begin
      exp_addr = (exp_q.size() > 0) ? exp_q.pop_front() : ~rd_ptr;
      chk({tag, ":read_order"}, 32'(rd_ptr), 32'(exp_addr));
    end
    if (we) exp_q.push_back(m_wr);
    @(posedge clk);
    #1;
    if (c) begin
      model_reset();
    end else begin
      m_ovf = m_ovf | (wr & isfull);
      m_udf = m_udf | (rd & isempty);
      if (we) m_wr = inc_wrap(m_wr);
      if (re) m_rd = inc_wrap(m_rd);
      if (we && !re) m_count++;
      if (re && !we) m_count--;
      m_rv = re;
    end
    check_state(tag);
  endtask

  initial begin
    // reset
    #12;
    chk("rst:count", 32'(count), 32'd0);
    chk("rst:empty", 32'(empty), 32'd1);
    chk("rst:full", 32'(full), 32'd0);
    chk("rst:almost_empty", 32'(almost_empty), 32'd1);
    chk("rst:almost_full", 32'(almost_full), 32'd0);
    chk("rst:rd_valid", 32'(rd_valid), 32'd0);
    chk("rst:flags", 32'({overflow, underflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // fill to full, then overflow
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, 1'b0, "fill");
      chk("fill:count_hand", 32'(count), 32'(i + 1));
      chk("fill:afull_hand", 32'(almost_full), 32'(i + 1 >= 6));
    end
    chk("fill:full_hand", 32'(full), 32'd1);
    chk("fill:wr_wrap_hand", 32'(wr_ptr), 32'd0);
    step(1'b1, 1'b0, 1'b0, "ovf");
    chk("ovf:overflow_hand", 32'(overflow), 32'd1);
    chk("ovf:count_hand", 32'(count), 32'd8);

    // drain to empty, then underflow
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 1'b0, "drain");
      chk("drain:rd_valid_hand", 32'(rd_valid), 32'd1);
      chk("drain:count_hand", 32'(count), 32'(7 - i));
    end
    chk("drain:empty_hand", 32'(empty), 32'd1);
    chk("drain:rd_wrap_hand", 32'(rd_ptr), 32'd0);
    step(1'b0, 1'b1, 1'b0, "udf");
    chk("udf:underflow_hand", 32'(underflow), 32'd1);
    chk("udf:rd_valid_hand", 32'(rd_valid), 32'd0);

    // clear, then steady simultaneous traffic at count=4
    step(1'b0, 1'b0, 1'b1, "clr1");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "to4");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 1'b0, "both");
    chk("both:count_hand", 32'(count), 32'd4);
    chk("both:wr_ptr_hand", 32'(wr_ptr), 32'd0);
    chk("both:rd_ptr_hand", 32'(rd_ptr), 32'd4);

    // simultaneous requests at full and at empty
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "to8");
    step(1'b1, 1'b1, 1'b0, "bothfull");
    chk("bothfull:count_hand", 32'(count), 32'd7);
    chk("bothfull:overflow_hand", 32'(overflow), 32'd1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, "to0");
    step(1'b1, 1'b1, 1'b0, "bothempty");
    chk("bothempty:count_hand", 32'(count), 32'd1);
    chk("bothempty:underflow_hand", 32'(underflow), 32'd1);

    // clr beats a write at count=5 with overflow set
    step(1'b0, 1'b0, 1'b1, "clr2");
    for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0, "to9");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, "to5");
    chk("pre_clr:count_hand", 32'(count), 32'd5);
    chk("pre_clr:overflow_hand", 32'(overflow), 32'd1);
    step(1'b1, 1'b0, 1'b1, "clrwr");
    chk("clrwr:count_hand", 32'(count), 32'd0);
    chk("clrwr:ptrs_hand", 32'({wr_ptr, rd_ptr}), 32'd0);
    chk("clrwr:overflow_hand", 32'(overflow), 32'd0);
    chk("clrwr:rd_valid_hand", 32'(rd_valid), 32'd0);

    // asynchronous reset mid-operation at count=3 with rd_valid=1
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, "to4b");
    step(1'b0, 1'b1, 1'b0, "to3");
    chk("pre_rst:count_hand", 32'(count), 32'd3);
    chk("pre_rst:rd_valid_hand", 32'(rd_valid), 32'd1);
    wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async:count", 32'(count), 32'd0);
    chk("async:rd_valid", 32'(rd_valid), 32'd0);
    chk("async:ptrs", 32'({wr_ptr, rd_ptr}), 32'd0);
    chk("async:empty", 32'(empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, "post_rst");
    chk("post_rst:count_hand", 32'(count), 32'd1);
    chk("post_rst:wr_ptr_hand", 32'(wr_ptr), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the synchronous 8-bit FIFO.
- Sits directly upstream of the FIFO storage array. Turns raw producer/consumer requests into qualified write_en/read_en and wr_ptr/rd_ptr for the array.
- Owns occupancy count, full/empty, almost-full/almost-empty, sticky overflow/underflow, and a read-data-valid strobe aligned to the array's registered data_out.

Parameters:
- DEPTH, 8, number of entries; any value 2..2**ADDR_W.
- ADDR_W, 3, pointer width; must satisfy 2**ADDR_W >= DEPTH.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req  in  1  producer write request.
- rd_req  in  1  consumer read request.
- clr  in  1  synchronous flush.
- write_en  out  1  qualified write to array; combinational.
- read_en  out  1  qualified read to array; combinational.
- wr_ptr  out  ADDR_W  array write address; registered.
- rd_ptr  out  ADDR_W  array read address; registered.
- rd_valid  out  1  array data_out valid this cycle; registered.
- count  out  ADDR_W+1  current occupancy 0..DEPTH; registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- overflow  out  1  sticky: write attempted while full.
- underflow  out  1  sticky: read attempted while empty.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, rd_valid=0, overflow=0, underflow=0. Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
- Qualification:
  - write_en = wr_req & ~full & ~clr
  - read_en = rd_req & ~empty & ~clr
  - full/empty are decoded from registered count, so they never depend on same-cycle requests.
- Pointer update:
  - On write_en: wr_ptr increments; wraps DEPTH-1 -> 0 by explicit compare, so non-power-of-two DEPTH is legal.
  - On read_en: rd_ptr increments with the same wrap rule.
- Count update: +1 on write_en only; -1 on read_en only; unchanged when both or neither fire.
- Simultaneous wr_req+rd_req:
  - When full: read accepted, write rejected, overflow set; count goes DEPTH -> DEPTH-1.
  - When empty: write accepted, read rejected, underflow set; count goes 0 -> 1.
  - Otherwise: both accepted, count unchanged, both pointers advance.
- rd_valid: equals read_en delayed one cycle, matching the array's one-cycle registered read latency. Cleared by clr.
- Sticky flags:
  - overflow sets on (wr_req & full & ~clr); underflow sets on (rd_req & empty & ~clr).
  - Both hold until clr or reset.
- clr has priority over all requests: next cycle pointers=0, count=0, rd_valid=0, sticky flags=0. Array contents are not erased, and stale data is unreachable because empty=1.
- Reset mid-operation: all state returns to reset values immediately, independent of clk. The first edge after rst_n rises behaves as from empty.
- Invariant, checked by the bench: (wr_ptr - rd_ptr) mod DEPTH == count mod DEPTH at all times.
- Integration: the array resets on active-high rst, so the top level drives it with ~rst_n.

Decomposition:
- Shared package holds:
  - FIFO_DEPTH=8, FIFO_ADDR_W=3, FIFO_DATA_W=8.
  - Default AFULL/AEMPTY thresholds.
  - A ptr_t typedef for ADDR_W-wide pointers.
- One natural sub-module: fifo_ptr_wrap, a parameterised increment-with-wrap pointer register instantiated twice (write side, read side).
- Count, flags and sticky logic stay in fifo_ctrl.

Test Plan:
- Reset, then 8 writes with rd_req=0 -> count steps 1..8; full=1 after 8th; almost_full=1 from count=6; wr_ptr wraps 7->0; a 9th wr_req gives write_en=0 and overflow=1.
- From full, 8 reads -> read_en each cycle; rd_valid=1 one cycle after each read_en; rd_ptr wraps 7->0; empty=1 after 8th; a further rd_req gives underflow=1.
- Count=4, wr_req=rd_req=1 for 20 cycles -> count stays 4; both pointers advance 20 mod 8; invariant holds every cycle.
- Full, wr_req=rd_req=1 -> write_en=0, read_en=1, count=7, overflow=1. Empty, both high -> write_en=1, read_en=0, count=1, underflow=1.
- Count=5, overflow=1, assert clr with wr_req=1 -> write_en=0; next cycle count=0, pointers=0, overflow=0, rd_valid=0.
- Drop rst_n mid-cycle with count=3 and rd_valid=1 -> outputs reach reset values before the next clk edge; after release, a single write gives count=1 and wr_ptr=1.
